sys_array_result_streamer: RTL and testbench

//  Downstream stage of sys_array_fetcher: captures the ARRAY_W x ARRAY_W result matrix (out_data) when the fetcher signals ready.

---
 rtl/sys_array_pkg.sv | 17 +
 rtl/sys_array_result_buf.sv | 27 ++
 rtl/sys_array_result_streamer.sv | 132 +++++++++++++
 tb/tb_sys_array_result_streamer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and default sizing for the systolic-array result path.
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CSUM   = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ARRAY_W    = 5;
    localparam int IDX_W          = $clog2(DEF_ARRAY_W);
    localparam int RES_W          = 2 * DEF_DATA_WIDTH;

    typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/sys_array_result_buf.sv
// Capture register bank for one ARRAY_W x ARRAY_W result matrix with a (row,col) read mux.
module sys_array_result_buf
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_W    = DEF_ARRAY_W
) (
    input  logic                                              clk,
    input  logic                                              load,
    input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] din,
    input  logic [$clog2(ARRAY_W)-1:0]                        rd_row,
    input  logic [$clog2(ARRAY_W)-1:0]                        rd_col,
    output logic [2*DATA_WIDTH-1:0]                           rd_data
);

    logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] mem_p0;

    // Data-only storage: never reset, contents change only on a capture.
    always_ff @(posedge clk) begin
        if (load) begin
            mem_p0 <= din;
        end
    end

    assign rd_data = mem_p0[rd_row][rd_col];

endmodule

// File: rtl/sys_array_result_streamer.sv
// Captures the fetcher's result matrix on a res_ready rising edge and streams it row-major
// on a valid/ready port. Define STREAM_CHECKSUM_EN to append a modular-sum beat per frame.
module sys_array_result_streamer
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ARRAY_W    = DEF_ARRAY_W,
    parameter int ARRAY_L    = 2
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              res_ready,
    input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] res_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [2*DATA_WIDTH-1:0]                           out_data,
    output logic [$clog2(ARRAY_W)-1:0]                        out_row,
    output logic [$clog2(ARRAY_W)-1:0]                        out_col,
    output logic                                              out_last,
    output logic                                              busy,
    output logic                                              overrun
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int IW = $clog2(ARRAY_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(ARRAY_W - 1);
    localparam logic [IW-1:0] PEN_IDX  = IW'(ARRAY_W - 2);

    if (ARRAY_L < 1 || ARRAY_W < 2) begin : g_bad_params
        $error("sys_array_result_streamer: ARRAY_L must be >= 1 and ARRAY_W >= 2");
    end

`ifdef STREAM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t        state;
    logic          res_ready_q;
    logic          cap;
    logic          xfer;
    logic          at_last;
    logic          frame_end;
    logic          load;
    logic [RW-1:0] elem;

    assign cap       = res_ready & ~res_ready_q;
    assign xfer      = out_valid & out_ready;
    assign at_last   = (out_row == LAST_IDX) && (out_col == LAST_IDX);
    assign frame_end = xfer & (((state == STREAM) && at_last && !CSUM_EN) || (state == CSUM));
    // A capture is accepted when idle or exactly as the current frame's final beat leaves.
    assign load      = cap & ((state == IDLE) || frame_end);
    assign busy      = (state != IDLE);

    sys_array_result_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ARRAY_W    (ARRAY_W)
    ) u_buf (
        .clk     (clk),
        .load    (load),
        .din     (res_data),
        .rd_row  (out_row),
        .rd_col  (out_col),
        .rd_data (elem)
    );

    // The edge register also tracks during reset so a level held high across reset never captures.
    always_ff @(posedge clk) begin
        res_ready_q <= res_ready;
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (cap && !load) begin
                overrun <= 1'b1;
            end
            if (load) begin
                state     <= STREAM;
                out_valid <= 1'b1;
                out_row   <= '0;
                out_col   <= '0;
                out_last  <= 1'b0;
            end else if (frame_end) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_row   <= '0;
                out_col   <= '0;
                out_last  <= 1'b0;
            end else if (xfer && (state == STREAM)) begin
                if (at_last) begin
`ifdef STREAM_CHECKSUM_EN
                    state    <= CSUM;
                    out_row  <= '0;
                    out_col  <= '0;
                    out_last <= 1'b1;
`endif
                end else begin
                    if (out_col == LAST_IDX) begin
                        out_col <= '0;
                        out_row <= out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                    out_last <= !CSUM_EN && (out_row == LAST_IDX) && (out_col == PEN_IDX);
                end
            end
        end
    end

`ifdef STREAM_CHECKSUM_EN
    logic [RW-1:0] sum_p0;

    // Wraps modulo 2^RW by construction of the register width.
    always_ff @(posedge clk) begin
        if (load) begin
            sum_p0 <= '0;
        end else if (xfer && (state == STREAM)) begin
            sum_p0 <= sum_p0 + elem;
        end
    end

    assign out_data = !out_valid ? '0 : ((state == CSUM) ? sum_p0 : elem);
`else
    assign out_data = out_valid ? elem : '0;
`endif

endmodule

// File: tb/tb_sys_array_result_streamer.sv
// Scoreboard bench for sys_array_result_streamer (W=5, L=2, DW=8), honours STREAM_CHECKSUM_EN.
module tb_sys_array_result_streamer;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int L  = 2;
    localparam int RW = 2 * DW;
    localparam int IW = $clog2(W);
`ifdef STREAM_CHECKSUM_EN
    localparam int FRAME = W * W + 1;
`else
    localparam int FRAME = W * W;
`endif

    typedef logic [0:W-1][0:W-1][RW-1:0] mat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          res_ready = 1'b0;
    logic          out_ready = 1'b0;
    mat_t          res_data;
    logic          out_valid;
    logic [RW-1:0] out_data;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic          out_last;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    mat_t mat_c, mat_d, mat_e;

    always #5 clk = ~clk;

    sys_array_result_streamer #(
        .DATA_WIDTH (DW),
        .ARRAY_W    (W),
        .ARRAY_L    (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .res_ready (res_ready),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic l, input logic [IW-1:0] r,
                                         input logic [IW-1:0] c, input logic [RW-1:0] d);
        return 64'({l, r, c, d});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input mat_t m);
`ifdef STREAM_CHECKSUM_EN
        logic [RW-1:0] s;
        s = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                s = s + m[r][c];
                exp_q.push_back(beat(1'b0, IW'(r), IW'(c), m[r][c]));
            end
        end
        exp_q.push_back(beat(1'b1, '0, '0, s));
`else
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_q.push_back(beat((r == W-1) && (c == W-1), IW'(r), IW'(c), m[r][c]));
            end
        end
`endif
    endtask

    task automatic capture(input mat_t m);
        res_data  = m;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("cap_latency", out_valid, 1);
        push_frame(m);
    endtask

    task automatic run_frame(input bit toggle, input int edge_beat, input bit edge_new,
                             input mat_t edge_mat, input int stop_beats, output int beats);
        int          cyc;
        bit          stalled;
        bit          want_valid;
        logic [63:0] held;
        logic [63:0] cur;
        cyc        = 0;
        stalled    = 1'b0;
        want_valid = 1'b0;
        held       = '0;
        beats      = 0;
        while (exp_q.size() != 0 && beats < stop_beats && cyc < 400) begin
            res_ready = 1'b0;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            cur = beat(out_last, out_row, out_col, out_data);
            if (stalled) check("hold", {cur[62:0], out_valid}, {held[62:0], 1'b1});
            if (want_valid) check("no_bubble", out_valid, 1);
            want_valid = 1'b0;
            if (out_valid && out_ready) begin
                check("beat", cur, exp_q.pop_front());
                if (beats == edge_beat) begin
                    res_data  = edge_mat;
                    res_ready = 1'b1;
                    if (edge_new) begin
                        push_frame(edge_mat);
                        want_valid = 1'b1;
                    end
                end
                beats++;
            end
            stalled = out_valid && !out_ready;
            held    = cur;
            step();
            cyc++;
        end
        res_ready = 1'b0;
        if (cyc >= 400) check("timeout", cyc, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < L; k++) acc += (2*r + k + 1) * (2*c + k + 1);
                mat_c[r][c] = RW'(acc);
                mat_d[r][c] = RW'(r * 40 + c * 7 + 1000);
                mat_e[r][c] = RW'(acc) ^ 16'hA5A5;
            end
        end
        res_data = '0;

        reset = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", {out_row, out_col}, 0);

        // Basic frame with the consumer always ready
        capture(mat_c);
        run_frame(1'b0, -1, 1'b0, mat_c, 1000, n);
        check("s1_count", n, FRAME);
        check_idle("s1_end");

        // Back-pressure: ready toggling
        capture(mat_c);
        run_frame(1'b1, -1, 1'b0, mat_c, 1000, n);
        check("s2_count", n, FRAME);
        check_idle("s2_end");

        // New result edge coincident with the final beat transfer
        capture(mat_c);
        run_frame(1'b0, FRAME - 1, 1'b1, mat_d, 1000, n);
        check("s4_count", n, 2 * FRAME);
        check("s4_overrun", overrun, 0);
        check_idle("s4_end");

        // Edge mid-frame is dropped and flagged
        capture(mat_c);
        run_frame(1'b0, 9, 1'b0, mat_e, 1000, n);
        check("s3_count", n, FRAME);
        check("s3_overrun", overrun, 1);
        check_idle("s3_end");
        repeat (10) step();
        check("s3_dropped", out_valid, 0);
        check("s3_sticky", overrun, 1);

        // Reset in the middle of a frame with res_ready held high
        capture(mat_c);
        run_frame(1'b0, -1, 1'b0, mat_c, 7, n);
        check("s5_partial", n, 7);
        exp_q.delete();
        res_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("s5_valid", out_valid, 0);
        check("s5_busy", busy, 0);
        check("s5_overrun", overrun, 0);
        check("s5_last", out_last, 0);
        repeat (4) step();
        check("s5_no_cap", out_valid, 0);
        check("s5_no_busy", busy, 0);
        res_ready = 1'b0;
        step();
        capture(mat_d);
        run_frame(1'b0, -1, 1'b0, mat_d, 1000, n);
        check("s5_count", n, FRAME);
        check_idle("s5_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
